// File: rtl/sha256_mem_pkg.sv
// Shared types and constants for the SHA-256 memory responder.
package sha256_mem_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        LOAD,
        KICK,
        WAIT_BUSY,
        WAIT_DONE,
        DRAIN_RD,
        DRAIN_OUT
    } state_e;

    localparam int unsigned HASH_WORDS = 8;
    localparam word_t       BAD_READ   = 32'hDEADBEEF;

endpackage

// File: rtl/sha256_mem_responder_if.sv
// Host stream + SHA core memory port bundle. Optional err signal with SHA_RESP_BOUNDS_EN.
interface sha256_mem_responder_if;
    import sha256_mem_pkg::*;

    logic        in_valid;
    logic        in_ready;
    word_t       in_data;
    logic        out_valid;
    logic        out_ready;
    word_t       out_data;
    logic        out_last;
    logic        busy;
    logic [15:0] run_cycles;
    logic        sha_start;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        sha_done;
    logic [15:0] mem_addr;
    logic        mem_we;
    word_t       mem_write_data;
    word_t       mem_read_data;
`ifdef SHA_RESP_BOUNDS_EN
    logic        err;
`endif

    // Responder side.
    modport slave (
`ifdef SHA_RESP_BOUNDS_EN
        output err,
`endif
        input  in_valid, in_data, out_ready, sha_done, mem_addr, mem_we, mem_write_data,
        output in_ready, out_valid, out_data, out_last, busy, run_cycles, sha_start,
        output message_addr, output_addr, mem_read_data
    );

    // Host and core side.
    modport master (
`ifdef SHA_RESP_BOUNDS_EN
        input  err,
`endif
        output in_valid, in_data, out_ready, sha_done, mem_addr, mem_we, mem_write_data,
        input  in_ready, out_valid, out_data, out_last, busy, run_cycles, sha_start,
        input  message_addr, output_addr, mem_read_data
    );

endinterface

// File: rtl/sha256_word_ram.sv
// Single-port DEPTH x 32 word RAM: synchronous write, registered read with read enable.
module sha256_word_ram
    import sha256_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  word_t             wdata_i,
    input  logic              re_i,
    output word_t             rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    word_t mem_q [Depth];
    word_t rdata_q, rdata_d;

    // Read samples the array before the same-edge write lands (read-before-write).
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem_q[addr_i];
    end

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sha256_mem_responder.sv
// Host sequencer and memory responder for the SHA-256 core memory port.
// Define SHA_RESP_BOUNDS_EN to reject core accesses beyond DEPTH and expose a sticky err.
module sha256_mem_responder
    import sha256_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter logic [15:0] MSG_BASE     = 16'd0,
    parameter logic [15:0] OUT_BASE     = 16'd32
) (
    input logic                   clk,
    input logic                   reset_n,
    sha256_mem_responder_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [15:0]       run_q, run_d;
    logic              sha_start_q, sha_start_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;
    logic              core_rd_q, core_rd_d;
    word_t             hold_q, hold_d;

    logic              core_phase;
    logic              core_oob;
    logic              in_hs;
    word_t             core_rdata;
    word_t             mem_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    word_t             ram_wdata;
    logic              ram_re;
    word_t             ram_rdata;

    assign core_phase = (state_q == KICK) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    assign in_hs      = bus.in_valid && in_ready_q;

`ifdef SHA_RESP_BOUNDS_EN
    logic err_q, err_d;
    logic oob_rd_q, oob_rd_d;

    assign core_oob   = |bus.mem_addr[15:ADDR_W];
    assign core_rdata = oob_rd_q ? BAD_READ : ram_rdata;
    assign bus.err    = err_q;
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^bus.mem_addr[15:ADDR_W];
    assign core_oob       = 1'b0;
    assign core_rdata     = ram_rdata;
`endif

    // Core sees fresh data only after a core-phase read; otherwise the last value is held.
    assign mem_rdata = core_rd_q ? core_rdata : hold_q;

    always_comb begin
        ram_addr  = bus.mem_addr[ADDR_W-1:0];
        ram_we    = 1'b0;
        ram_wdata = bus.mem_write_data;
        ram_re    = 1'b0;
        unique case (state_q)
            LOAD: begin
                ram_addr  = MSG_BASE[ADDR_W-1:0] + cnt_q;
                ram_we    = in_hs;
                ram_wdata = bus.in_data;
            end
            KICK, WAIT_BUSY, WAIT_DONE: begin
                ram_we = bus.mem_we && !core_oob;
                ram_re = 1'b1;
            end
            DRAIN_RD: begin
                ram_addr = OUT_BASE[ADDR_W-1:0] + ADDR_W'(idx_q);
                ram_re   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        run_d   = run_q;
        unique case (state_q)
            LOAD: begin
                if (in_hs) begin
                    if (cnt_q == ADDR_W'(NUM_OF_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = KICK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            KICK: begin
                run_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
                // sha_done idles high, so only a low level proves the core has started.
                if (!bus.sha_done) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
                if (bus.sha_done) begin
                    idx_d   = '0;
                    state_d = DRAIN_RD;
                end
            end
            DRAIN_RD: state_d = DRAIN_OUT;
            DRAIN_OUT: begin
                if (bus.out_ready) begin
                    if (idx_q == 3'(HASH_WORDS - 1)) begin
                        state_d = LOAD;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = DRAIN_RD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        sha_start_d = (state_d == KICK);
        busy_d      = (state_d != LOAD);
        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == DRAIN_OUT);
        out_last_d  = (state_d == DRAIN_OUT) && (idx_d == 3'(HASH_WORDS - 1));
        core_rd_d   = core_phase;
        hold_d      = mem_rdata;
`ifdef SHA_RESP_BOUNDS_EN
        oob_rd_d    = core_phase && core_oob;
        err_d       = err_q || (core_phase && core_oob);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            idx_q       <= '0;
            run_q       <= '0;
            sha_start_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            core_rd_q   <= 1'b0;
            hold_q      <= '0;
`ifdef SHA_RESP_BOUNDS_EN
            oob_rd_q    <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            sha_start_q <= sha_start_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            core_rd_q   <= core_rd_d;
            hold_q      <= hold_d;
`ifdef SHA_RESP_BOUNDS_EN
            oob_rd_q    <= oob_rd_d;
            err_q       <= err_d;
`endif
        end
    end

    sha256_word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    // RAM output register is stable for the whole DRAIN_OUT stay.
    assign bus.out_data      = out_valid_q ? ram_rdata : '0;
    assign bus.out_last      = out_last_q;
    assign bus.busy          = busy_q;
    assign bus.run_cycles    = run_q;
    assign bus.sha_start     = sha_start_q;
    assign bus.message_addr  = MSG_BASE;
    assign bus.output_addr   = OUT_BASE;
    assign bus.mem_read_data = mem_rdata;

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Randomised bench for sha256_mem_responder against a word-array reference model.
module tb_sha256_mem_responder;

    localparam int NW    = 20;
    localparam int MSGB  = 0;
    localparam int OUTB  = 32;
    localparam int DEPTH = 64;

    logic clk;
    logic reset_n;

    sha256_mem_responder_if bus ();

    sha256_mem_responder u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          core_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic noise();
        bus.mem_we         = 1'($urandom_range(0, 1));
        bus.mem_addr       = 16'($urandom);
        bus.mem_write_data = $urandom;
    endtask

    // Model one clock edge, then move to the next sampling point.
    task automatic tick();
        int a;
        if (core_cyc) begin
`ifdef SHA_RESP_BOUNDS_EN
            if (bus.mem_addr >= 16'(DEPTH)) begin
                exp_rd  = 32'hDEADBEEF;
                exp_err = 1'b1;
            end else begin
                a      = int'(bus.mem_addr);
                exp_rd = mdl[a];
                if (bus.mem_we) mdl[a] = bus.mem_write_data;
            end
`else
            a      = int'(bus.mem_addr) % DEPTH;
            exp_rd = mdl[a];
            if (bus.mem_we) mdl[a] = bus.mem_write_data;
`endif
        end
        @(negedge clk);
        check_eq("mem_read_data", bus.mem_read_data, exp_rd);
`ifdef SHA_RESP_BOUNDS_EN
        check_eq("err", 32'(bus.err), 32'(exp_err));
`endif
    endtask

    task automatic check_reset_vals();
        check_eq("rst_sha_start", 32'(bus.sha_start), 0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_out_last", 32'(bus.out_last), 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_mem_read_data", bus.mem_read_data, 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_run_cycles", 32'(bus.run_cycles), 0);
`ifdef SHA_RESP_BOUNDS_EN
        check_eq("rst_err", 32'(bus.err), 0);
`endif
    endtask

    task automatic release_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mem_we    = 1'b0;
        bus.sha_done  = 1'b1;
        core_cyc      = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_rd  = '0;
        exp_err = 1'b0;
        tick();
    endtask

    // Asserted mid-cycle, well away from the rising edge.
    task automatic apply_reset();
        #2 reset_n = 1'b0;
        #1 check_reset_vals();
        release_reset();
    endtask

    task automatic core_op(input int j, input bit pat);
        int t;
        bus.mem_we         = 1'b0;
        bus.mem_write_data = $urandom;
        bus.mem_addr       = 16'($urandom_range(0, DEPTH - 1));
        if (j == 0 || j == 2) begin
            bus.mem_addr = 16'd5;
        end else if (j == 1) begin
            bus.mem_addr       = 16'd5;
            bus.mem_we         = 1'b1;
            bus.mem_write_data = 32'hFFFF_FFFF;
        end else if (j == 3) begin
            bus.mem_addr = 16'd64;
            bus.mem_we   = 1'b1;
        end else if (j == 4) begin
            bus.mem_addr = 16'd64;
        end else if (j <= 12) begin
            bus.mem_addr = 16'(OUTB + j - 5);
            bus.mem_we   = 1'b1;
            if (pat) bus.mem_write_data = 32'hA5A5_0000 + 32'(j - 5);
        end else if (pat) begin
            // Fill every word outside the hash area so later random reads hit known data.
            t = j - 13;
            if (t < 12) begin
                bus.mem_addr = 16'(20 + t);
                bus.mem_we   = 1'b1;
            end else if (t < 36) begin
                bus.mem_addr = 16'(40 + t - 12);
                bus.mem_we   = 1'b1;
            end else begin
                bus.mem_addr = 16'($urandom_range(0, 39));
            end
        end else begin
            bus.mem_addr = 16'($urandom_range(0, 2 * DEPTH - 1));
            bus.mem_we   = 1'($urandom_range(0, 1));
        end
    endtask

    // abort: 0 none, 1 reset during load, 2 reset during drain.
    task automatic run_job(input int h, input int l, input bit pat, input int abort);
        int          cnt;
        int          k;
        int          guard;
        bit          tog;
        bit          prev_hs;
        bit          exp_v;
        logic [31:0] hw [8];

        cnt      = 0;
        tog      = 1'b0;
        core_cyc = 1'b0;
        while (cnt < NW) begin
            check_eq("in_ready_load", 32'(bus.in_ready), 1);
            check_eq("busy_load", 32'(bus.busy), 0);
            check_eq("sha_start_load", 32'(bus.sha_start), 0);
            if (abort == 1 && cnt == 7) begin
                apply_reset();
                return;
            end
            bus.in_valid = pat ? tog : 1'($urandom_range(0, 1));
            tog          = !tog;
            bus.in_data  = pat ? 32'h1000_0000 + 32'(cnt) : $urandom;
            noise();
            if (bus.in_valid) begin
                mdl[(MSGB + cnt) % DEPTH] = bus.in_data;
                cnt++;
            end
            tick();
        end

        check_eq("sha_start_kick", 32'(bus.sha_start), 1);
        check_eq("in_ready_kick", 32'(bus.in_ready), 0);
        check_eq("busy_kick", 32'(bus.busy), 1);
        check_eq("message_addr", 32'(bus.message_addr), MSGB);
        check_eq("output_addr", 32'(bus.output_addr), OUTB);
        for (int i = 0; i < NW; i++) begin
            check_eq("ram_backdoor", u_dut.u_ram.mem_q[(MSGB + i) % DEPTH],
                     mdl[(MSGB + i) % DEPTH]);
        end

        for (int j = 0; j <= h + l; j++) begin
            if (j > 0) begin
                check_eq("sha_start_wait", 32'(bus.sha_start), 0);
                check_eq("in_ready_wait", 32'(bus.in_ready), 0);
                check_eq("busy_wait", 32'(bus.busy), 1);
                check_eq("out_valid_wait", 32'(bus.out_valid), 0);
                check_eq("run_cycles_wait", 32'(bus.run_cycles), 32'(j - 1));
            end
            bus.sha_done = (j < h) || (j >= h + l);
            bus.in_valid = 1'($urandom_range(0, 1));
            core_op(j, pat);
            core_cyc = 1'b1;
            tick();
        end
        core_cyc = 1'b0;

        for (int i = 0; i < 8; i++) hw[i] = mdl[(OUTB + i) % DEPTH];
        bus.sha_done = 1'b1;
        k       = 0;
        prev_hs = 1'b1;
        guard   = 0;
        while (k < 8 && guard < 400) begin
            // One empty read cycle precedes every word; valid never drops unaccepted.
            exp_v = !prev_hs;
            check_eq("out_valid_drain", 32'(bus.out_valid), 32'(exp_v));
            check_eq("out_last_drain", 32'(bus.out_last), 32'(exp_v && k == 7));
            if (exp_v) check_eq("out_data", bus.out_data, hw[k]);
            check_eq("run_cycles_done", 32'(bus.run_cycles), 32'(h + l));
            check_eq("busy_drain", 32'(bus.busy), 1);
            check_eq("in_ready_drain", 32'(bus.in_ready), 0);
            if (abort == 2 && k == 3) begin
                apply_reset();
                return;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = 1'($urandom_range(0, 1));
            noise();
            prev_hs = exp_v && bus.out_ready;
            if (prev_hs) k++;
            guard++;
            tick();
        end
        if (k < 8) check_eq("drain_timeout", 32'(k), 8);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_eq("in_ready_after", 32'(bus.in_ready), 1);
        check_eq("busy_after", 32'(bus.busy), 0);
        check_eq("out_valid_after", 32'(bus.out_valid), 0);
        check_eq("out_last_after", 32'(bus.out_last), 0);
    endtask

    initial begin
        reset_n            = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.out_ready      = 1'b0;
        bus.sha_done       = 1'b1;
        bus.mem_addr       = '0;
        bus.mem_we         = 1'b0;
        bus.mem_write_data = '0;
        exp_rd             = '0;
        exp_err            = 1'b0;
        core_cyc           = 1'b0;
        @(negedge clk);
        #1 check_reset_vals();
        release_reset();

        run_job(3, 100, 1'b1, 0);
        run_job(1, 13, 1'b0, 0);
        repeat (3) run_job($urandom_range(1, 6), $urandom_range(13, 60), 1'b0, 0);
        run_job(2, 20, 1'b0, 2);
        run_job(2, 15, 1'b0, 1);
        run_job(4, 30, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
